// File: rtl/minterm_extractor.sv
// minterm_extractor
//   Scans a latched truth table one bit per cycle and streams the index of
//   every set bit (minterm) in ascending order over a valid/ready stream.
//   When the scan finishes it pulses done and publishes the minterm count.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        begin a scan (honoured only while idle)
//   truth_table  bit i = F at input combination i (index MSB = first variable)
//   busy         high whenever a scan is in progress (any state but idle)
//   m_valid      minterm beat valid
//   m_ready      downstream accepts the current beat
//   m_index      minterm index of the current beat
//   m_last       current beat is the final minterm of the table
//   done         one-cycle pulse at scan end
//   count        number of minterms emitted by the last completed scan
module minterm_extractor #(
   parameter int unsigned N_VARS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [(1 << N_VARS)-1:0]   truth_table,
   output logic                       busy,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [N_VARS-1:0]          m_index,
   output logic                       m_last,
   output logic                       done,
   output logic [N_VARS:0]            count
);

   localparam int unsigned TBL_W = 1 << N_VARS;

   localparam logic [N_VARS-1:0] IDX_ONE = N_VARS'(1);
   localparam logic [N_VARS-1:0] IDX_MAX = '1;
   localparam logic [N_VARS:0]   CNT_ONE = (N_VARS + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_EMIT,
      ST_DONE
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [TBL_W-1:0]    tbl;
   logic [TBL_W-1:0]    tbl_next;
   logic [N_VARS-1:0]   idx;
   logic [N_VARS-1:0]   idx_next;
   logic [N_VARS:0]     run_cnt;
   logic [N_VARS:0]     run_cnt_next;
   logic [N_VARS:0]     count_next;
   logic [TBL_W-1:0]    above_idx;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         tbl     <= '0;
         idx     <= '0;
         run_cnt <= '0;
         count   <= '0;
      end else begin
         state   <= state_next;
         tbl     <= tbl_next;
         idx     <= idx_next;
         run_cnt <= run_cnt_next;
         count   <= count_next;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_next   = state;
      tbl_next     = tbl;
      idx_next     = idx;
      run_cnt_next = run_cnt;
      count_next   = count;

      case (state)
         ST_IDLE: begin
            if (start) begin
               tbl_next     = truth_table;
               idx_next     = '0;
               run_cnt_next = '0;
               state_next   = ST_SCAN;
            end
         end

         ST_SCAN: begin
            if (tbl[idx]) begin
               state_next = ST_EMIT;
            end else if (idx == IDX_MAX) begin
               // count is published on entry to DONE so it is already
               // valid during the done pulse
               count_next = run_cnt;
               state_next = ST_DONE;
            end else begin
               idx_next = idx + IDX_ONE;
            end
         end

         ST_EMIT: begin
            if (m_ready) begin
               run_cnt_next = run_cnt + CNT_ONE;
               if (idx == IDX_MAX) begin
                  count_next = run_cnt + CNT_ONE;
                  state_next = ST_DONE;
               end else begin
                  idx_next   = idx + IDX_ONE;
                  state_next = ST_SCAN;
               end
            end
         end

         ST_DONE: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from state; idx and tbl are frozen in EMIT, which
   // keeps the beat stable for the whole stall.
   always_comb begin
      above_idx = (tbl >> idx) >> 1;
      busy      = (state != ST_IDLE);
      m_valid   = (state == ST_EMIT);
      m_index   = (state == ST_EMIT) ? idx : '0;
      m_last    = (state == ST_EMIT) && (above_idx == '0);
      done      = (state == ST_DONE);
   end

endmodule
